// File: rtl/decode_pkg.sv
// RV32I decode-stage types: instruction classes, immediate formats, opcode/funct7 constants.
package decode_pkg;

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OPIMM   = 4'd7,
    CLS_OP      = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_MULDIV  = 4'd11,
    CLS_ILLEGAL = 4'd12
  } opclass_t;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_t;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] imm;
    opclass_t    opclass;
    logic [2:0]  funct3;
    logic        alt;
    logic        illegal;
  } decode_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; opcode bits [6:0] never contribute to an immediate.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:7] instr,
  input  logic [2:0]  fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:     imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:     imm = {instr[31:12], 12'b0};
      FMT_J:     imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_SHAMT: imm = {27'b0, instr[24:20]};
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/instruction_decoder.sv
// Single-entry RV32I decode stage with valid/ready handshake and registered decoded fields.
// Optional DECODE_MULDIV_EN: decode OP with funct7=0000001 as MULDIV instead of illegal.
module instruction_decoder
  import decode_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [4:0]          rs1_addr,
  output logic [4:0]          rs2_addr,
  output logic [4:0]          rd_addr,
  output logic                rd_we,
  output logic [31:0]         imm,
  output logic [3:0]          opclass,
  output logic [2:0]          funct3,
  output logic                alt,
  output logic                illegal
);

  logic                out_valid_q, out_valid_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  decode_t             dec_q, dec_d, dec_new;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  opclass_t    cls;
  imm_fmt_t    fmt;
  logic        ill, alt_n, writes;
  logic [31:0] imm_new;

  imm_gen u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (fmt),
    .imm   (imm_new)
  );

  always_comb begin
    opc   = in_instr[6:0];
    f3    = in_instr[14:12];
    f7    = in_instr[31:25];
    cls   = CLS_ILLEGAL;
    fmt   = FMT_NONE;
    ill   = 1'b0;
    alt_n = 1'b0;
    // All legal opcodes end in 2'b11, so a compressed/invalid low pair falls to default.
    case (opc)
      OPCODE_LUI:    begin cls = CLS_LUI;   fmt = FMT_U; end
      OPCODE_AUIPC:  begin cls = CLS_AUIPC; fmt = FMT_U; end
      OPCODE_JAL:    begin cls = CLS_JAL;   fmt = FMT_J; end
      OPCODE_JALR:   begin cls = CLS_JALR;  fmt = FMT_I; ill = (f3 != 3'd0); end
      OPCODE_BRANCH: begin cls = CLS_BRANCH; fmt = FMT_B; ill = (f3 == 3'd2) || (f3 == 3'd3); end
      OPCODE_LOAD:   begin cls = CLS_LOAD;  fmt = FMT_I; ill = (f3 == 3'd3) || (f3 >= 3'd6); end
      OPCODE_STORE:  begin cls = CLS_STORE; fmt = FMT_S; ill = (f3 > 3'd2); end
      OPCODE_OPIMM: begin
        cls = CLS_OPIMM;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          fmt   = FMT_SHAMT;
          alt_n = in_instr[30];
          ill   = !((f7 == F7_BASE) || (f7 == F7_ALT && f3 == 3'b101));
        end else begin
          fmt = FMT_I;
        end
      end
      OPCODE_OP: begin
        cls = CLS_OP;
        if (f7 == F7_MULDIV) begin
`ifdef DECODE_MULDIV_EN
          cls = CLS_MULDIV;
`else
          ill = 1'b1;
`endif
        end else begin
          alt_n = in_instr[30];
          ill   = !((f7 == F7_BASE) || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
        end
      end
      OPCODE_FENCE:  cls = CLS_FENCE;
      OPCODE_SYSTEM: begin cls = CLS_SYSTEM; ill = (f3 != 3'd0); end
      default:       ill = 1'b1;
    endcase
    if (ill) begin
      cls   = CLS_ILLEGAL;
      alt_n = 1'b0;
    end

    dec_new         = '0;
    dec_new.opclass = cls;
    dec_new.imm     = imm_new;
    dec_new.rd      = in_instr[11:7];
    dec_new.funct3  = f3;
    dec_new.alt     = alt_n;
    dec_new.illegal = ill;
    case (cls)
      CLS_JALR, CLS_LOAD, CLS_OPIMM:           dec_new.rs1 = in_instr[19:15];
      CLS_BRANCH, CLS_STORE, CLS_OP, CLS_MULDIV: begin
        dec_new.rs1 = in_instr[19:15];
        dec_new.rs2 = in_instr[24:20];
      end
      default: ;
    endcase
    case (cls)
      CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD,
      CLS_OPIMM, CLS_OP, CLS_MULDIV:           writes = 1'b1;
      default:                                 writes = 1'b0;
    endcase
    dec_new.rd_we = writes && (in_instr[11:7] != 5'd0);
  end

  assign in_ready = (!out_valid_q || out_ready) && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    pc_d        = pc_q;
    dec_d       = dec_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid_d = 1'b1;
      pc_d        = in_pc;
      dec_d       = dec_new;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      dec_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pc_q        <= pc_d;
      dec_q       <= dec_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = pc_q;
  assign rs1_addr  = dec_q.rs1;
  assign rs2_addr  = dec_q.rs2;
  assign rd_addr   = dec_q.rd;
  assign rd_we     = dec_q.rd_we;
  assign imm       = dec_q.imm;
  assign opclass   = dec_q.opclass;
  assign funct3    = dec_q.funct3;
  assign alt       = dec_q.alt;
  assign illegal   = dec_q.illegal;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder; expected values are hand-decoded from the RV32I encodings.
module tb_instruction_decoder;

  localparam logic [3:0] C_LUI = 4'd0, C_AUIPC = 4'd1, C_JAL = 4'd2, C_JALR = 4'd3,
                         C_BRANCH = 4'd4, C_LOAD = 4'd5, C_STORE = 4'd6, C_OPIMM = 4'd7,
                         C_OP = 4'd8, C_FENCE = 4'd9, C_SYSTEM = 4'd10, C_MULDIV = 4'd11,
                         C_ILLEGAL = 4'd12;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rd_we, alt, illegal;
  logic [3:0]  opclass;
  logic [2:0]  funct3;

  int checks = 0;
  int errors = 0;

  instruction_decoder #(.PC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rd_we(rd_we), .imm(imm), .opclass(opclass), .funct3(funct3),
    .alt(alt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction for a single cycle; no checking here.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (imm !== 32'h0) begin errors++; $display("FAIL reset_imm got %h want 0", imm); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", out_pc); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_addi();
    issue(32'hFFF08293, 32'h0000_1000);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", out_valid); end
    checks++; if (rs1_addr !== 5'd1) begin errors++; $display("FAIL addi_rs1 got %0d want 1", rs1_addr); end
    checks++; if (rd_addr !== 5'd5) begin errors++; $display("FAIL addi_rd got %0d want 5", rd_addr); end
    checks++; if (imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h want ffffffff", imm); end
    checks++; if (opclass !== C_OPIMM) begin errors++; $display("FAIL addi_class got %0d want %0d", opclass, C_OPIMM); end
    checks++; if (rd_we !== 1'b1) begin errors++; $display("FAIL addi_we got %b want 1", rd_we); end
    checks++; if (out_pc !== 32'h1000) begin errors++; $display("FAIL addi_pc got %h want 1000", out_pc); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_consume got %b want 0", out_valid); end
  endtask

  task automatic test_branch();
    issue(32'hFE208EE3, 32'h0000_1004);
    checks++; if (imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm got %h want fffffffc", imm); end
    checks++; if (rs1_addr !== 5'd1) begin errors++; $display("FAIL beq_rs1 got %0d want 1", rs1_addr); end
    checks++; if (rs2_addr !== 5'd2) begin errors++; $display("FAIL beq_rs2 got %0d want 2", rs2_addr); end
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL beq_we got %b want 0", rd_we); end
    checks++; if (opclass !== C_BRANCH) begin errors++; $display("FAIL beq_class got %0d want %0d", opclass, C_BRANCH); end
    tick();
  endtask

  task automatic test_nop();
    issue(32'h00000013, 32'h0000_1008);
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL nop_illegal got %b want 0", illegal); end
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL nop_we got %b want 0", rd_we); end
    tick();
  endtask

  task automatic test_muldiv();
    issue(32'h022081B3, 32'h0000_100C);
`ifdef DECODE_MULDIV_EN
    checks++; if (opclass !== C_MULDIV) begin errors++; $display("FAIL mul_class got %0d want %0d", opclass, C_MULDIV); end
    checks++; if (rd_we !== 1'b1) begin errors++; $display("FAIL mul_we got %b want 1", rd_we); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL mul_illegal got %b want 0", illegal); end
`else
    checks++; if (opclass !== C_ILLEGAL) begin errors++; $display("FAIL mul_class got %0d want %0d", opclass, C_ILLEGAL); end
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL mul_we got %b want 0", rd_we); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL mul_illegal got %b want 1", illegal); end
`endif
    tick();
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        we;
    logic        ill;
    logic        alt;
  } vec_t;

  task automatic test_formats();
    vec_t v[16];
    v[0]  = '{32'h123453B7, 32'h12345000, C_LUI,    5'd0, 5'd0, 1'b1, 1'b0, 1'b0}; // lui x7,0x12345
    v[1]  = '{32'h80000297, 32'h80000000, C_AUIPC,  5'd0, 5'd0, 1'b1, 1'b0, 1'b0}; // auipc x5,0x80000
    v[2]  = '{32'h008000EF, 32'h00000008, C_JAL,    5'd0, 5'd0, 1'b1, 1'b0, 1'b0}; // jal x1,8
    v[3]  = '{32'h000280E7, 32'h00000000, C_JALR,   5'd5, 5'd0, 1'b1, 1'b0, 1'b0}; // jalr x1,0(x5)
    v[4]  = '{32'hFF812303, 32'hFFFFFFF8, C_LOAD,   5'd2, 5'd0, 1'b1, 1'b0, 1'b0}; // lw x6,-8(x2)
    v[5]  = '{32'h0020A423, 32'h00000008, C_STORE,  5'd1, 5'd2, 1'b0, 1'b0, 1'b0}; // sw x2,8(x1)
    v[6]  = '{32'h40315093, 32'h00000003, C_OPIMM,  5'd2, 5'd0, 1'b1, 1'b0, 1'b1}; // srai x1,x2,3
    v[7]  = '{32'h402081B3, 32'h00000000, C_OP,     5'd1, 5'd2, 1'b1, 1'b0, 1'b1}; // sub x3,x1,x2
    v[8]  = '{32'h0FF0000F, 32'h00000000, C_FENCE,  5'd0, 5'd0, 1'b0, 1'b0, 1'b0}; // fence
    v[9]  = '{32'h00000073, 32'h00000000, C_SYSTEM, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0}; // ecall
    v[10] = '{32'h40111093, 32'h0,        C_ILLEGAL,5'd0, 5'd0, 1'b0, 1'b1, 1'b0}; // slli with alt funct7
    v[11] = '{32'h00013083, 32'h0,        C_ILLEGAL,5'd0, 5'd0, 1'b0, 1'b1, 1'b0}; // load funct3=3
    v[12] = '{32'h00000000, 32'h0,        C_ILLEGAL,5'd0, 5'd0, 1'b0, 1'b1, 1'b0}; // low bits 00
    v[13] = '{32'h402091B3, 32'h0,        C_ILLEGAL,5'd0, 5'd0, 1'b0, 1'b1, 1'b0}; // OP alt with funct3=1
    v[14] = '{32'h000290E7, 32'h0,        C_ILLEGAL,5'd0, 5'd0, 1'b0, 1'b1, 1'b0}; // jalr funct3=1
    v[15] = '{32'hFE20AEE3, 32'h0,        C_ILLEGAL,5'd0, 5'd0, 1'b0, 1'b1, 1'b0}; // branch funct3=2
    for (int i = 0; i < 16; i++) begin
      issue(v[i].instr, 32'h2000 + 32'(i) * 4);
      checks++; if (opclass !== v[i].cls) begin errors++; $display("FAIL fmt%0d_class got %0d want %0d", i, opclass, v[i].cls); end
      if (!v[i].ill) begin
        checks++; if (imm !== v[i].imm) begin errors++; $display("FAIL fmt%0d_imm got %h want %h", i, imm, v[i].imm); end
      end
      checks++; if (rs1_addr !== v[i].rs1) begin errors++; $display("FAIL fmt%0d_rs1 got %0d want %0d", i, rs1_addr, v[i].rs1); end
      checks++; if (rs2_addr !== v[i].rs2) begin errors++; $display("FAIL fmt%0d_rs2 got %0d want %0d", i, rs2_addr, v[i].rs2); end
      checks++; if (rd_we !== v[i].we) begin errors++; $display("FAIL fmt%0d_we got %b want %b", i, rd_we, v[i].we); end
      checks++; if (illegal !== v[i].ill) begin errors++; $display("FAIL fmt%0d_illegal got %b want %b", i, illegal, v[i].ill); end
      checks++; if (alt !== v[i].alt) begin errors++; $display("FAIL fmt%0d_alt got %b want %b", i, alt, v[i].alt); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = 32'h00000013;
      in_pc    = 32'h100 + 32'(i) * 4;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b want 1", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(i) * 4) begin
        errors++; $display("FAIL b2b_out%0d got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, 32'h100 + 32'(i) * 4);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_stall_flush();
    out_ready = 1'b0;
    issue(32'hFFF08293, 32'h200);
    in_valid = 1'b1; in_instr = 32'h123453B7; in_pc = 32'h204;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    tick(); tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || imm !== 32'hFFFFFFFF || rd_addr !== 5'd5) begin
      errors++; $display("FAIL stall_hold got v=%b pc=%h imm=%h rd=%0d want v=1 pc=200 imm=ffffffff rd=5",
                         out_valid, out_pc, imm, rd_addr);
    end
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
    flush = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_capture got %b want 0", out_valid); end
    issue(32'h123453B7, 32'h204);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h204 || imm !== 32'h12345000) begin
      errors++; $display("FAIL flush_represent got v=%b pc=%h imm=%h want v=1 pc=204 imm=12345000", out_valid, out_pc, imm);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    issue(32'hFFF08293, 32'h300);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rststall_pre got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || imm !== 32'h0 || out_pc !== 32'h0 || rd_addr !== 5'd0) begin
      errors++; $display("FAIL rststall_clear got v=%b imm=%h pc=%h rd=%0d want all 0", out_valid, imm, out_pc, rd_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rststall_release got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_nop();
    test_muldiv();
    test_formats();
    test_back_to_back();
    test_stall_flush();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
